ring_buffer_reader: RTL and testbench
=====================================

// Module: ring_buffer_reader
// PURPOSE
//  Read-side initiator for the Ring_Buffer (REG_WIDTH=8, PTR_SIZE=3 in the top-level).
//  Watches isEmpty and issues single-cycle read commands on the buffer's 2-bit mode port.
//  Captures RData and presents each word on a valid/ready stream towards the consumer.
//  Never issues writes. At most one read is outstanding, so no word is lost or duplicated under backpressure.
// PARAMETERS
//  REG_WIDTH   8  data word width; must match the Ring_Buffer.
//  RD_LATENCY  1  edges from the edge that samples mode=R to the edge where RData is valid to capture (1..3).
//  CNT_W       8  width of the delivered-word counter rd_count.
// PORTS
//  clk        in   1          single clock, rising edge.
//  reset      in   1          asynchronous, active-high reset.
//  enable     in   1          1 = reader may issue new reads.
//  buf_empty  in   1          Ring_Buffer isEmpty.
//  buf_rdata  in   REG_WIDTH  Ring_Buffer RData.
//  buf_mode   out  2          to Ring_Buffer mode: 2'b00 idle, 2'b01 read; 2'b10 (write) is never driven.
//  out_data   out  REG_WIDTH  word presented to the consumer.
//  out_valid  out  1          out_data holds a word.
//  out_ready  in   1          consumer accepts the word when out_valid && out_ready at a rising edge.
//  rd_count   out  CNT_W      number of words handed off, modulo 2^CNT_W.
//  busy       out  1          1 when state != IDLE or out_valid = 1.
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE, buf_mode=00, out_valid=0, out_data=0, rd_count=0, busy=0.
//  buf_mode is registered and decoded from state only: 01 in ISSUE, 00 in every other state.
//  FSM:
//   IDLE: go to ISSUE when all of these hold:
//    - enable = 1
//    - buf_empty = 0
//    - (out_valid = 0 or out_valid && out_ready in this cycle)
//   ISSUE: buf_mode=01 for exactly one cycle; load the wait counter with RD_LATENCY-1; go to WAIT.
//   WAIT: decrement the wait counter. At the edge where it reaches zero:
//    - out_data <= buf_rdata and out_valid <= 1
//    - go to IDLE
//  Latency:
//   - IDLE to out_valid is RD_LATENCY+2 edges.
//   - Peak throughput is one word per RD_LATENCY+2 cycles; buf_empty is re-sampled only in IDLE.
//  Output slot: out_data is stable while out_valid=1 && out_ready=0.
//   - Handshake clears out_valid unless a capture happens on the same edge.
//   - If a capture coincides with a handshake, out_valid stays 1 and the new data is loaded.
//  rd_count increments on each handshake and wraps from 2^CNT_W-1 to 0 without a flag.
//  enable falling in ISSUE or WAIT: the in-flight read completes and its word is delivered; no new read is issued.
//  buf_empty changing in ISSUE or WAIT: ignored.
//  buf_empty asserted with enable=1: stay in IDLE with buf_mode=00 indefinitely.
//  Reset during ISSUE or WAIT: the in-flight word is dropped. The buffer's read pointer has already advanced; this loss is accepted.
// STRUCTURE
//  Shared package ring_buffer_pkg:
//   - constants MODE_IDLE=2'b00, MODE_R=2'b01, MODE_W=2'b10 (reused by the writer side)
//   - reader state encoding RD_IDLE / RD_ISSUE / RD_WAIT
//  One sub-module, rb_out_slot: a single-entry valid/ready holding register with a load port and the rd_count counter.
//  The FSM and wait counter stay in ring_buffer_reader.
// TESTING (bench instantiates Ring_Buffer REG_WIDTH=8, PTR_SIZE=3 plus this reader; bench drives the write side)
//  1. Reset held, random inputs -> buf_mode=00, out_valid=0, rd_count=0, busy=0 throughout.
//  2. Write 1,2,3,4; enable=1, out_ready=1 ->
//     - out_data 1,2,3,4 in order
//     - exactly 4 one-cycle buf_mode=01 pulses
//     - rd_count=4, then idle with buf_mode=00
//  3. Write 5,6; out_ready=0 for 20 cycles ->
//     - exactly one read pulse
//     - out_data=5 stable, out_valid=1
//     - after out_ready=1, 6 follows and rd_count increases by 2
//  4. Empty buffer, enable=1 for 50 cycles -> buf_mode never 01, busy=0.
//  5. Drop enable in the cycle after ISSUE -> that word is still delivered; no further read pulses while buf_empty=0.
//  6. Fill 8 words, CNT_W=3, drain all 8 -> the buffer goes empty; rd_count wraps to 0.
//     Assert reset mid-WAIT -> out_valid=0 within the same cycle.

Source files
------------

// File: rtl/ring_buffer_pkg.sv
// Shared definitions for the Ring_Buffer initiators: mode-port encodings and
// the reader FSM state type.
package ring_buffer_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_R    = 2'b01;
    localparam logic [1:0] MODE_W    = 2'b10;

    // Wide enough for RD_LATENCY-1 with RD_LATENCY in 1..3.
    localparam int WAIT_W = 2;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_ISSUE = 2'b01,
        RD_WAIT  = 2'b10
    } rd_state_t;

endpackage

// File: rtl/rb_out_slot.sv
// Single-entry valid/ready holding register for words read from the ring
// buffer, plus a modulo counter of words handed to the consumer.
module rb_out_slot #(
    parameter int REG_WIDTH = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [REG_WIDTH-1:0] load_data,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     rd_count
);

    // A word transfers on a rising edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_data holds. A load on the
    // transfer edge replaces the departing word and keeps out_valid high.
    logic handshake;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            rd_count  <= '0;
        end else begin
            if (load) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (handshake) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_buffer_reader.sv
// Read-side initiator for the Ring_Buffer: issues one read at a time when the
// buffer is non-empty and forwards each word on a valid/ready stream.
module ring_buffer_reader
    import ring_buffer_pkg::*;
#(
    parameter int REG_WIDTH  = 8,
    parameter int RD_LATENCY = 1,   // legal range 1..3
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 buf_empty,
    input  logic [REG_WIDTH-1:0] buf_rdata,
    output logic [1:0]           buf_mode,
    output logic [REG_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     rd_count,
    output logic                 busy,
    output rd_state_t            dbg_state
);

    rd_state_t         state;
    rd_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              capture;
    logic              slot_free;

    // The slot is free if empty, or if its word leaves on this same edge.
    assign slot_free = !out_valid || out_ready;
    assign capture   = (state == RD_WAIT) && (wait_cnt == '0);

    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE: begin
                if (enable && !buf_empty && slot_free) begin
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = RD_IDLE;
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // buf_mode is registered from the next state so it is high exactly while in ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RD_IDLE;
            buf_mode <= MODE_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            buf_mode <= (state_next == RD_ISSUE) ? MODE_R : MODE_IDLE;
            if (state == RD_ISSUE) begin
                wait_cnt <= WAIT_W'(RD_LATENCY - 1);
            end else if ((state == RD_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    rb_out_slot #(
        .REG_WIDTH (REG_WIDTH),
        .CNT_W     (CNT_W)
    ) u_out_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (capture),
        .load_data (buf_rdata),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .rd_count  (rd_count)
    );

    assign busy      = (state != RD_IDLE) || out_valid;
    assign dbg_state = state;

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Directed bench for ring_buffer_reader against a small behavioural model of
// the 8-entry Ring_Buffer (write side driven by the bench).
module tb_ring_buffer_reader;
    import ring_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] buf_mode;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] rd_count;
    logic       busy;
    rd_state_t  dbg_state;

    // Buffer model and reset-phase random overrides.
    logic [7:0] mem [8];
    logic [2:0] wptr = '0;
    logic [2:0] rptr = '0;
    logic [3:0] m_cnt = '0;
    logic [7:0] m_rdata = '0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       m_rd;
    logic       rand_en = 1'b1;
    logic       r_empty = 1'b1;
    logic [7:0] r_data = '0;
    logic       dut_empty;
    logic [7:0] dut_rdata;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         pulses = 0;
    int         p0;
    logic [1:0] prev_mode = MODE_IDLE;

    always #5 clk = ~clk;

    assign m_rd      = (buf_mode == MODE_R) && (m_cnt != 4'd0);
    assign dut_empty = rand_en ? r_empty : (m_cnt == 4'd0);
    assign dut_rdata = rand_en ? r_data : m_rdata;

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
            wptr      <= wptr + 3'd1;
        end
        if (m_rd) begin
            m_rdata <= mem[rptr];
            rptr    <= rptr + 3'd1;
        end
        m_cnt <= m_cnt + {3'b000, wr_en} - {3'b000, m_rd};
    end

    ring_buffer_reader #(
        .REG_WIDTH  (8),
        .RD_LATENCY (1),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .enable    (enable),
        .buf_empty (dut_empty),
        .buf_rdata (dut_rdata),
        .buf_mode  (buf_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_count  (rd_count),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake must deliver the oldest written word; read pulses are one cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("hs_unexpected", exp_q.size(), 1);
            else check("hs_data", out_data, exp_q.pop_front());
        end
        if (buf_mode == MODE_R) begin
            pulses++;
            check("pulse_len", prev_mode, MODE_IDLE);
        end else begin
            check("mode_idle", buf_mode, MODE_IDLE);
        end
        prev_mode <= buf_mode;
    end

    task automatic drive_step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_word(input logic [7:0] d);
        drive_step();
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
    endtask

    task automatic write_stop();
        drive_step();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max);
        logic done = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, done, 1);
    endtask

    task automatic wait_pulse(input string tag, input int max);
        logic done = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (buf_mode == MODE_R) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, done, 1);
    endtask

    initial begin
        // 1: reset held with random inputs
        for (int i = 0; i < 20; i++) begin
            drive_step();
            enable    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            r_empty   = 1'($urandom_range(0, 1));
            r_data    = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("rst_mode", buf_mode, MODE_IDLE);
            check("rst_valid", out_valid, 0);
            check("rst_count", rd_count, 0);
            check("rst_busy", busy, 0);
        end
        drive_step();
        rand_en   = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b1;
        drive_step();
        rst = 1'b0;

        // 2: four words streamed with ready high
        p0 = pulses;
        write_word(8'd1); write_word(8'd2); write_word(8'd3); write_word(8'd4);
        write_stop();
        enable = 1'b1;
        wait_drain("t2_drain", 100);
        check("t2_pulses", pulses - p0, 4);
        check("t2_count", rd_count, 3'd4);
        repeat (3) @(negedge clk);
        check("t2_idle_mode", buf_mode, MODE_IDLE);
        check("t2_idle_busy", busy, 0);

        // 3: backpressure holds word 5, only one read outstanding
        drive_step();
        out_ready = 1'b0;
        p0 = pulses;
        write_word(8'd5); write_word(8'd6);
        write_stop();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_valid", out_valid, 1);
            check("t3_data", out_data, 8'd5);
        end
        check("t3_one_pulse", pulses - p0, 1);
        drive_step();
        out_ready = 1'b1;
        wait_drain("t3_drain", 100);
        check("t3_pulses", pulses - p0, 2);
        check("t3_count", rd_count, 3'd6);

        // 4: empty buffer, enable held
        p0 = pulses;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t4_busy", busy, 0);
        end
        check("t4_no_pulse", pulses - p0, 0);

        // 5: enable dropped in the cycle after ISSUE
        drive_step();
        enable = 1'b0;
        write_word(8'd20); write_word(8'd21);
        write_stop();
        p0 = pulses;
        enable = 1'b1;
        wait_pulse("t5_issue", 20);
        drive_step();
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_left", exp_q.size(), 1);
        check("t5_pulses", pulses - p0, 1);
        check("t5_not_empty", dut_empty, 0);
        check("t5_count", rd_count, 3'd7);
        check("t5_busy", busy, 0);
        drive_step();
        enable = 1'b1;
        wait_drain("t5_drain", 100);
        check("t5_count_wrap", rd_count, 3'd0);

        // 6: fill all eight entries and drain; counter wraps again
        drive_step();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) write_word(8'(100 + i));
        write_stop();
        p0 = pulses;
        enable = 1'b1;
        wait_drain("t6_drain", 200);
        check("t6_pulses", pulses - p0, 8);
        check("t6_empty", dut_empty, 1);
        check("t6_count", rd_count, 3'd0);

        // Reset in WAIT drops the in-flight word
        write_word(8'd55);
        write_stop();
        wait_pulse("t6_issue", 20);
        @(posedge clk);
        #1;
        check("t6_wait_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_mode", buf_mode, MODE_IDLE);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_post_valid", out_valid, 0);
        check("t6_post_count", rd_count, 3'd0);
        check("t6_post_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
